// File: rtl/lcd_bus_pkg.sv
// ============================================================================
// Module      : lcd_bus_pkg
// Description : Shared opcodes, status bit positions, FSM states and RAM
//               address packing for the KS0108-style panel responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_bus_pkg;

    localparam int ADDR_COL_W  = 6;
    localparam int ADDR_PAGE_W = 3;

    localparam logic [7:0] OP_ON      = 8'h3E;
    localparam logic [7:0] OP_ON_MASK = 8'hFE;
    localparam logic [1:0] OP_Y       = 2'b01;
    localparam logic [4:0] OP_PAGE    = 5'b10111;
    localparam logic [1:0] OP_START   = 2'b11;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_OFF   = 5;
    localparam int STAT_RESET = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WR0  = 3'd2,
        ST_WR1  = 3'd3,
        ST_RDF  = 3'd4,
        ST_BUSY = 3'd5
    } state_t;

    function automatic logic [ADDR_PAGE_W+ADDR_COL_W:0] pack_addr(
        input logic                   chip,
        input logic [ADDR_PAGE_W-1:0] page,
        input logic [ADDR_COL_W-1:0]  col
    );
        return {chip, page, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_chip_regs.sv
// ============================================================================
// Module      : lcd_chip_regs
// Description : On/off, page, column and start-line registers of one chip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_chip_regs #(
    parameter int COL_W  = 6,
    parameter int PAGE_W = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              ld_on_i,
    input  logic              ld_page_i,
    input  logic              ld_col_i,
    input  logic              ld_start_i,
    input  logic              inc_col_i,
    input  logic [7:0]        data_i,
    output logic              on_o,
    output logic [PAGE_W-1:0] page_o,
    output logic [COL_W-1:0]  col_o,
    output logic [COL_W-1:0]  start_o
);

    logic              on_q, on_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COL_W-1:0]  start_q, start_d;

    always_comb begin
        on_d    = on_q;
        page_d  = page_q;
        col_d   = col_q;
        start_d = start_q;
        if (clr_i) begin
            on_d    = 1'b0;
            page_d  = '0;
            col_d   = '0;
            start_d = '0;
        end else begin
            if (ld_on_i)    on_d    = data_i[0];
            if (ld_page_i)  page_d  = data_i[PAGE_W-1:0];
            if (ld_start_i) start_d = data_i[COL_W-1:0];
            // Column counter wraps naturally at the top of the range.
            if (ld_col_i)       col_d = data_i[COL_W-1:0];
            else if (inc_col_i) col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            on_q    <= 1'b0;
            page_q  <= '0;
            col_q   <= '0;
            start_q <= '0;
        end else begin
            on_q    <= on_d;
            page_q  <= page_d;
            col_q   <= col_d;
            start_q <= start_d;
        end
    end

    assign on_o    = on_q;
    assign page_o  = page_q;
    assign col_o   = col_q;
    assign start_o = start_q;

endmodule

`default_nettype wire

// File: rtl/lcd_panel_model.sv
// ============================================================================
// Module      : lcd_panel_model
// Description : Two-chip KS0108-style LCD bus responder with display RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_panel_model
    import lcd_bus_pkg::*;
#(
    parameter int BUSY_CYCLES = 4,
    parameter int COL_W       = ADDR_COL_W,
    parameter int PAGE_W      = ADDR_PAGE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  rw_i,
    input  logic                  dori_i,
    input  logic [1:0]            cs_i,
    input  logic [7:0]            db_i,
    output logic [7:0]            db_o,
    output logic                  db_oe_o,
    output logic                  busy_o,
    output logic                  ram_we_o,
    output logic [PAGE_W+COL_W:0] ram_addr_o,
    output logic [7:0]            ram_wdata_o,
    input  logic [7:0]            ram_rdata_i,
    output logic [1:0]            disp_on_o,
    output logic [COL_W-1:0]      start_line0_o,
    output logic [COL_W-1:0]      start_line1_o
);

    localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    logic             en_q, en_d;
    logic             cap_rw_q, cap_rw_d, cap_dori_q, cap_dori_d;
    logic [1:0]       cap_cs_q, cap_cs_d;
    logic [7:0]       cap_db_q, cap_db_d;
    logic             op_rw_q, op_rw_d, op_dori_q, op_dori_d;
    logic [1:0]       op_cs_q, op_cs_d;
    logic [7:0]       op_db_q, op_db_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [7:0]       latch_q, latch_d;
    logic [7:0]       dbo_q, dbo_d;

    logic [1:0]              ld_on, ld_page, ld_col, ld_start, inc_col;
    logic [1:0]              chip_on;
    logic [PAGE_W-1:0]       chip_page  [2];
    logic [COL_W-1:0]        chip_col   [2];
    logic [COL_W-1:0]        chip_start [2];
    logic                    ram_we;
    logic [PAGE_W+COL_W:0]   ram_addr;
    logic [7:0]              ram_wdata;
    logic                    fall, accept, rd_chip;
    logic [7:0]              status;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_chip
            lcd_chip_regs #(.COL_W(COL_W), .PAGE_W(PAGE_W)) u_regs (
                .clk        (clk),
                .rstn       (rstn),
                .clr_i      (rst_i),
                .ld_on_i    (ld_on[i]),
                .ld_page_i  (ld_page[i]),
                .ld_col_i   (ld_col[i]),
                .ld_start_i (ld_start[i]),
                .inc_col_i  (inc_col[i]),
                .data_i     (op_db_q),
                .on_o       (chip_on[i]),
                .page_o     (chip_page[i]),
                .col_o      (chip_col[i]),
                .start_o    (chip_start[i])
            );
        end
    endgenerate

    assign busy_o  = (state_q != ST_IDLE);
    assign fall    = en_q & ~en_i;
    // Status reads are served entirely from the output latch path, so they never start the FSM.
    assign accept  = fall && (state_q == ST_IDLE) && (cap_cs_q != 2'b00)
                     && !(cap_rw_q && !cap_dori_q);
    assign rd_chip = ~cs_i[0];

    always_comb begin
        status             = 8'h00;
        status[STAT_BUSY]  = busy_o;
        status[STAT_OFF]   = ~chip_on[rd_chip];
        status[STAT_RESET] = rst_i;
    end

    always_comb begin
        en_d       = rst_i ? 1'b0 : en_i;
        cap_rw_d   = cap_rw_q;
        cap_dori_d = cap_dori_q;
        cap_cs_d   = cap_cs_q;
        cap_db_d   = cap_db_q;
        op_rw_d    = op_rw_q;
        op_dori_d  = op_dori_q;
        op_cs_d    = op_cs_q;
        op_db_d    = op_db_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_pend_d  = 1'b0;
        latch_d    = rd_pend_q ? ram_rdata_i : latch_q;
        dbo_d      = dbo_q;
        ld_on      = 2'b00;
        ld_page    = 2'b00;
        ld_col     = 2'b00;
        ld_start   = 2'b00;
        inc_col    = 2'b00;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = 8'h00;

        if (en_i) begin
            cap_rw_d   = rw_i;
            cap_dori_d = dori_i;
            cap_cs_d   = cs_i;
            cap_db_d   = db_i;
            if (rw_i && (cs_i != 2'b00)) dbo_d = dori_i ? latch_q : status;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_rw_d   = cap_rw_q;
                    op_dori_d = cap_dori_q;
                    op_cs_d   = cap_cs_q;
                    op_db_d   = cap_db_q;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!op_dori_q) begin
                    ld_on    = ((op_db_q & OP_ON_MASK) == OP_ON) ? op_cs_q : 2'b00;
                    ld_col   = (op_db_q[7:6] == OP_Y)            ? op_cs_q : 2'b00;
                    ld_page  = (op_db_q[7:3] == OP_PAGE)         ? op_cs_q : 2'b00;
                    ld_start = (op_db_q[7:6] == OP_START)        ? op_cs_q : 2'b00;
                    state_d  = ST_BUSY;
                    cnt_d    = CNT_W'(BUSY_CYCLES - 1);
                end else if (!op_rw_q) begin
                    state_d = op_cs_q[0] ? ST_WR0 : ST_WR1;
                end else begin
                    state_d = ST_RDF;
                end
            end
            ST_WR0: begin
                ram_we     = 1'b1;
                ram_addr   = pack_addr(1'b0, chip_page[0], chip_col[0]);
                ram_wdata  = op_db_q;
                inc_col[0] = 1'b1;
                state_d    = op_cs_q[1] ? ST_WR1 : ST_BUSY;
                cnt_d      = CNT_W'(BUSY_CYCLES - 1);
            end
            ST_WR1: begin
                ram_we     = 1'b1;
                ram_addr   = pack_addr(1'b1, chip_page[1], chip_col[1]);
                ram_wdata  = op_db_q;
                inc_col[1] = 1'b1;
                state_d    = ST_BUSY;
                cnt_d      = CNT_W'(BUSY_CYCLES - 1);
            end
            ST_RDF: begin
                ram_addr = op_cs_q[0] ? pack_addr(1'b0, chip_page[0], chip_col[0])
                                      : pack_addr(1'b1, chip_page[1], chip_col[1]);
                inc_col   = op_cs_q[0] ? 2'b01 : 2'b10;
                rd_pend_d = 1'b1;
                state_d   = ST_BUSY;
                cnt_d     = CNT_W'(BUSY_CYCLES - 1);
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Panel reset wins over everything except a status read, which reports it.
        if (rst_i) begin
            cap_rw_d   = 1'b0;
            cap_dori_d = 1'b0;
            cap_cs_d   = 2'b00;
            cap_db_d   = 8'h00;
            op_rw_d    = 1'b0;
            op_dori_d  = 1'b0;
            op_cs_d    = 2'b00;
            op_db_d    = 8'h00;
            state_d    = ST_IDLE;
            cnt_d      = '0;
            rd_pend_d  = 1'b0;
            latch_d    = 8'h00;
            dbo_d      = (en_i && rw_i && !dori_i && (cs_i != 2'b00)) ? status : 8'h00;
            ld_on      = 2'b00;
            ld_page    = 2'b00;
            ld_col     = 2'b00;
            ld_start   = 2'b00;
            inc_col    = 2'b00;
            ram_we     = 1'b0;
            ram_addr   = '0;
            ram_wdata  = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q       <= 1'b0;
            cap_rw_q   <= 1'b0;
            cap_dori_q <= 1'b0;
            cap_cs_q   <= 2'b00;
            cap_db_q   <= 8'h00;
            op_rw_q    <= 1'b0;
            op_dori_q  <= 1'b0;
            op_cs_q    <= 2'b00;
            op_db_q    <= 8'h00;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            latch_q    <= 8'h00;
            dbo_q      <= 8'h00;
        end else begin
            en_q       <= en_d;
            cap_rw_q   <= cap_rw_d;
            cap_dori_q <= cap_dori_d;
            cap_cs_q   <= cap_cs_d;
            cap_db_q   <= cap_db_d;
            op_rw_q    <= op_rw_d;
            op_dori_q  <= op_dori_d;
            op_cs_q    <= op_cs_d;
            op_db_q    <= op_db_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            latch_q    <= latch_d;
            dbo_q      <= dbo_d;
        end
    end

    assign db_o          = dbo_q;
    assign db_oe_o       = en_i & rw_i & (cs_i != 2'b00);
    assign ram_we_o      = ram_we;
    assign ram_addr_o    = ram_addr;
    assign ram_wdata_o   = ram_wdata;
    assign disp_on_o     = chip_on;
    assign start_line0_o = chip_start[0];
    assign start_line1_o = chip_start[1];

endmodule

`default_nettype wire
